// File: rtl/scoreboard_rank_receiver_if.sv
// scoreboard_rank_receiver_if: readout stream into the rank receiver and its ranked display/status outputs.
interface scoreboard_rank_receiver_if;
    logic [31:0] scoreboard_output;
    logic        scoreboard_parity;
    logic [15:0] display_userid;
    logic [15:0] display_score;
    logic [2:0]  display_rank;
    logic        display_valid;
    logic        busy;
    logic        done;
    logic [3:0]  entry_count;
    logic        timeout_err;
    modport master (
        output scoreboard_output, scoreboard_parity,
        input  display_userid, display_score, display_rank, display_valid,
        input  busy, done, entry_count, timeout_err
    );
    modport slave (
        input  scoreboard_output, scoreboard_parity,
        output display_userid, display_score, display_rank, display_valid,
        output busy, done, entry_count, timeout_err
    );
endinterface

// File: rtl/scoreboard_rank_receiver.sv
// scoreboard_rank_receiver: sorts streamed {userid,score} words into a top-TOP_N table, then cycles ranks to the display.
// Define SCOREBOARD_TIMEOUT_EN to abort a list after TIMEOUT_CYCLES idle clocks in COLLECT.
module scoreboard_rank_receiver #(
    parameter int TOP_N          = 4,
    parameter int DWELL_CYCLES   = 50_000_000,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                       clk,
    input logic                       rst,
    scoreboard_rank_receiver_if.slave bus
);
    localparam int DW = $clog2(DWELL_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, COLLECT, DONE, DISPLAY} state_t;
    state_t                 state, state_nx;
    logic [TOP_N-1:0][15:0] uid, scr, uid_nx, scr_nx, uid_sh, scr_sh;
    logic [TOP_N-1:0]       vld, vld_nx, vld_sh, base_vld, ge, ge_sh;
    logic [15:0]            w_uid, w_scr, sel_uid, sel_scr;
    logic [DW-1:0]          dwell;
    logic [2:0]             rank;
    logic [3:0]             count;
    logic                   parity_prev, tog, sentinel, start, ins, idle_to, dwell_end;

    if (TOP_N < 2 || TOP_N > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("scoreboard_rank_receiver: TOP_N must be 2..8 and TIMEOUT_CYCLES positive");
    end

    assign w_uid     = bus.scoreboard_output[31:16];
    assign w_scr     = bus.scoreboard_output[15:0];
    assign tog       = bus.scoreboard_parity ^ parity_prev;
    assign sentinel  = &bus.scoreboard_output;
    assign start     = tog && !sentinel && (state == IDLE || state == DISPLAY);
    assign ins       = tog && !sentinel && (start || state == COLLECT) && w_scr != 16'd0;
    assign dwell_end = dwell == DW'(DWELL_CYCLES - 1);

    always_comb begin
        state_nx = state;
        if (start) state_nx = COLLECT;
        else if (state == COLLECT && (sentinel || idle_to)) state_nx = DONE;
        else if (state == DONE) state_nx = DISPLAY;
    end

    // ge marks entries that stay ahead of the new word (>= keeps earlier arrivals ahead on ties);
    // it is a prefix mask, so the word lands just past it and everything behind shifts down one.
    always_comb begin
        base_vld = start ? '0 : vld;
        ge = '0;
        for (int i = 0; i < TOP_N; i++) ge[i] = base_vld[i] && scr[i] >= w_scr;
        ge_sh  = {ge[TOP_N-2:0], 1'b1};
        vld_sh = {base_vld[TOP_N-2:0], 1'b1};
        uid_sh = {uid[TOP_N-2:0], w_uid};
        scr_sh = {scr[TOP_N-2:0], w_scr};
        vld_nx = base_vld;
        uid_nx = uid;
        scr_nx = scr;
        for (int i = 0; i < TOP_N; i++)
            if (ins && !ge[i]) begin
                uid_nx[i] = ge_sh[i] ? w_uid : uid_sh[i];
                scr_nx[i] = ge_sh[i] ? w_scr : scr_sh[i];
                vld_nx[i] = ge_sh[i] | vld_sh[i];
            end
    end

    always_comb begin
        count   = '0;
        sel_uid = '0;
        sel_scr = '0;
        for (int i = 0; i < TOP_N; i++) begin
            count = count + 4'(vld[i]);
            if (rank == 3'(i)) begin
                sel_uid = uid[i];
                sel_scr = scr[i];
            end
        end
    end

    assign bus.display_userid = state == DISPLAY ? sel_uid : '0;
    assign bus.display_score  = state == DISPLAY ? sel_scr : '0;
    assign bus.display_rank   = state == DISPLAY ? rank : '0;
    assign bus.display_valid  = state == DISPLAY && count != 4'd0;
    assign bus.busy           = state == COLLECT;
    assign bus.done           = state == DONE;
    assign bus.entry_count    = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            vld         <= '0;
            uid         <= '0;
            scr         <= '0;
            parity_prev <= 1'b0;
            dwell       <= '0;
            rank        <= '0;
        end else begin
            state       <= state_nx;
            vld         <= vld_nx;
            uid         <= uid_nx;
            scr         <= scr_nx;
            parity_prev <= bus.scoreboard_parity;
            dwell       <= (state != DISPLAY || dwell_end) ? '0 : dwell + 1'b1;
            rank        <= state != DISPLAY ? '0 : !dwell_end ? rank :
                           ({1'b0, rank} + 4'd1 >= count) ? '0 : rank + 3'd1;
        end
    end

`ifdef SCOREBOARD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;
    logic          err;
    assign idle_to         = state == COLLECT && !tog && !sentinel && idle_cnt == TW'(TIMEOUT_CYCLES - 1);
    assign bus.timeout_err = err;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
            err      <= 1'b0;
        end else begin
            idle_cnt <= (state != COLLECT || tog || sentinel) ? '0 : idle_cnt + 1'b1;
            err      <= start ? 1'b0 : idle_to ? 1'b1 : err;
        end
    end
`else
    assign idle_to         = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_scoreboard_rank_receiver.sv
// tb_scoreboard_rank_receiver: table vectors, hand sequences and random lists checked against a queue-based ranking model.
module tb_scoreboard_rank_receiver;
    localparam int          TOP_N = 4;
    localparam int          DWELL = 4;
    localparam int          TMO   = 16;
    localparam logic [31:0] SENT  = 32'hFFFF_FFFF;

    typedef struct {
        int               n;
        logic [5:0][31:0] w;
        int               cnt;
        logic [3:0][31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    int          done_base = 0;
    logic [15:0] m_uid [$];
    logic [15:0] m_scr [$];
    logic [31:0] lst [$];
    vec_t        tv [6];

    scoreboard_rank_receiver_if bus ();

    scoreboard_rank_receiver #(
        .TOP_N(TOP_N), .DWELL_CYCLES(DWELL), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mkv(input int n, input logic [5:0][31:0] w, input int cnt, input logic [3:0][31:0] e);
        vec_t v;
        v.n = n;
        v.w = w;
        v.cnt = cnt;
        v.exp = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic send(input logic [31:0] w);
        @(negedge clk);
        bus.scoreboard_output = w;
        bus.scoreboard_parity = ~bus.scoreboard_parity;
    endtask

    // Reference ranking: sorted queue, insert before the first strictly lower score, keep TOP_N.
    function automatic void model_insert(input logic [31:0] w);
        int p = 0;
        if (w[15:0] == 16'd0) return;
        while (p < m_scr.size() && m_scr[p] >= w[15:0]) p++;
        if (p >= TOP_N) return;
        m_scr.insert(p, w[15:0]);
        m_uid.insert(p, w[31:16]);
        if (m_scr.size() > TOP_N) begin
            void'(m_scr.pop_back());
            void'(m_uid.pop_back());
        end
    endfunction

    task automatic wait_done(output int k);
        k = 0;
        while (bus.done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", bus.done, 1);
        chk("done_busy_low", bus.busy, 0);
        chk("done_rank_zero", bus.display_rank, 0);
    endtask

    task automatic check_display();
        int n;
        n = m_scr.size();
        chk("entry_count", bus.entry_count, n);
        @(negedge clk);
        chk("done_width", bus.done, 0);
        for (int k = 0; k <= 4 * (n == 0 ? 1 : n); k++) begin
            int r;
            r = n == 0 ? 0 : (k / 4) % n;
            chk("display_rank", bus.display_rank, r);
            chk("display_valid", bus.display_valid, n != 0);
            if (n != 0) begin
                chk("display_userid", bus.display_userid, m_uid[r]);
                chk("display_score", bus.display_score, m_scr[r]);
            end
            @(negedge clk);
        end
        chk("done_pulses", done_cnt - done_base, 1);
    endtask

    task automatic run_list(input bit use_model, input int gap_max);
        int k;
        done_base = done_cnt;
        if (use_model) begin
            m_uid.delete();
            m_scr.delete();
        end
        foreach (lst[i]) begin
            send(lst[i]);
            if (use_model) model_insert(lst[i]);
            if (i == 0) begin
                @(negedge clk);
                chk("start_busy", bus.busy, 1);
                chk("start_valid_drop", bus.display_valid, 0);
            end
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
        send(SENT);
        wait_done(k);
        chk("timeout_err_clear", bus.timeout_err, 0);
        check_display();
    endtask

    initial begin
        int k;
        bus.scoreboard_output = SENT;
        bus.scoreboard_parity = 1'b0;
        tv[0] = mkv(6, {32'h0005_0046, 32'h0004_0000, 32'h0003_0032, 32'h0002_001E, 32'h0001_0032, 32'h0000_000A},
                    4, {32'h0002_001E, 32'h0003_0032, 32'h0001_0032, 32'h0005_0046});
        tv[1] = mkv(2, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0002_0028, 32'h0007_0028},
                    2, {32'h0, 32'h0, 32'h0002_0028, 32'h0007_0028});
        tv[2] = mkv(3, {32'h0, 32'h0, 32'h0, 32'h0003_0007, 32'h0002_0009, 32'h0001_0005},
                    3, {32'h0, 32'h0001_0005, 32'h0003_0007, 32'h0002_0009});
        tv[3] = mkv(2, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0009_00C8, 32'h0004_0064},
                    2, {32'h0, 32'h0, 32'h0004_0064, 32'h0009_00C8});
        tv[4] = mkv(2, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0002_0000, 32'h0001_0000},
                    0, {32'h0, 32'h0, 32'h0, 32'h0});
        tv[5] = mkv(6, {32'h0006_0001, 32'h0005_0005, 32'h0004_0004, 32'h0003_0003, 32'h0002_0002, 32'h0001_0001},
                    4, {32'h0002_0002, 32'h0003_0003, 32'h0004_0004, 32'h0005_0005});
        #1;
        chk("reset_display", {bus.display_userid, bus.display_score}, 0);
        chk("reset_status", {bus.display_rank, bus.display_valid, bus.busy, bus.done, bus.entry_count, bus.timeout_err}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send(SENT);
        repeat (3) @(negedge clk);
        chk("idle_sentinel_busy", bus.busy, 0);
        chk("idle_sentinel_done", done_cnt, 0);

        for (int v = 0; v < 6; v++) begin
            lst.delete();
            m_uid.delete();
            m_scr.delete();
            for (int i = 0; i < tv[v].n; i++) lst.push_back(tv[v].w[i]);
            for (int i = 0; i < tv[v].cnt; i++) begin
                m_uid.push_back(tv[v].exp[i][31:16]);
                m_scr.push_back(tv[v].exp[i][15:0]);
            end
            run_list(1'b0, v == 1 ? 3 : 0);
        end

        // Sentinel placed on the bus without a parity toggle still ends the list.
        done_base = done_cnt;
        m_uid.delete();
        m_scr.delete();
        send(32'h0008_0011);
        model_insert(32'h0008_0011);
        send(32'h0009_0022);
        model_insert(32'h0009_0022);
        @(negedge clk);
        bus.scoreboard_output = SENT;
        wait_done(k);
        check_display();

        // Reset in the middle of a list.
        done_base = done_cnt;
        send(32'h0001_0010);
        send(32'h0002_0020);
        send(32'h0003_0030);
        @(negedge clk);
        chk("mid_busy", bus.busy, 1);
        chk("mid_count", bus.entry_count, 3);
        #2 rst = 1'b0;
        #1;
        chk("rst_display", {bus.display_userid, bus.display_score}, 0);
        chk("rst_status", {bus.display_rank, bus.display_valid, bus.busy, bus.done, bus.entry_count, bus.timeout_err}, 0);
        bus.scoreboard_parity = 1'b0;
        bus.scoreboard_output = SENT;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_no_done", done_cnt - done_base, 0);
        lst = '{32'h0003_004D};
        run_list(1'b1, 0);

        for (int t = 0; t < 25; t++) begin
            lst.delete();
            repeat ($urandom_range(1, 9)) lst.push_back({16'($urandom), 16'($urandom_range(0, 12))});
            run_list(1'b1, 2);
        end

`ifdef SCOREBOARD_TIMEOUT_EN
        done_base = done_cnt;
        m_uid.delete();
        m_scr.delete();
        send(32'h0001_000A);
        model_insert(32'h0001_000A);
        send(32'h0002_0014);
        model_insert(32'h0002_0014);
        wait_done(k);
        chk("timeout_latency", k, 17);
        chk("timeout_err_set", bus.timeout_err, 1);
        check_display();
        lst = '{32'h0004_0005};
        run_list(1'b1, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/scoreboard_rank_receiver.md
Name: scoreboard_rank_receiver

Overview:
- Receive end of the scoreboard readout stream: consumes the {userid, score} words that the scoreboard controller streams out of score RAM.
- Framing: one word per toggle of the parity line; the list ends with the all-ones sentinel.
- Keeps a sorted top-TOP_N table and, once the list completes, cycles the ranked entries to the display driver one at a time.

Parameters:
- TOP_N, 4, number of ranked entries retained (2..8).
- DWELL_CYCLES, 50_000_000, clocks each rank is shown before advancing.
- TIMEOUT_CYCLES, 1024, max idle clocks inside a list (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- scoreboard_output  in  32  word: [31:16] userid, [15:0] score; 32'hFFFF_FFFF = end-of-list sentinel.
- scoreboard_parity  in  1  toggles once per new data word.
- display_userid  out  16  userid of the currently shown rank.
- display_score  out  16  score of the currently shown rank.
- display_rank  out  3  rank index shown, 0 = highest.
- display_valid  out  1  high while a valid ranked entry is presented.
- busy  out  1  high while a list is being collected.
- done  out  1  one-clock pulse when a list completes.
- entry_count  out  4  number of valid table entries (0..TOP_N).
- timeout_err  out  1  sticky list-abort flag; tied 0 when the feature is absent.

Behaviour:
- Reset (rst low, async): state IDLE; table cleared; parity_prev=0; dwell counter=0.
  - All outputs 0.
- Word strobe: tog = scoreboard_parity ^ parity_prev, registered every clock; 1-clock detection latency.
- Sentinel: scoreboard_output==32'hFFFF_FFFF, level-detected. If tog and sentinel coincide, the word is treated as the sentinel and is not inserted.
- Filtering: words with score==0 are accepted (the strobe is consumed) but never inserted.
- Insertion (one clock, parallel compare):
  - New entry goes to the first rank i whose entry is invalid or has score strictly less.
  - Lower ranks shift down by one; the entry at TOP_N-1 is dropped.
  - Ties keep the earlier arrival ahead.
  - If no slot qualifies, the word is discarded.
- IDLE:
  - tog (non-sentinel): clear table, insert word, busy=1, go COLLECT.
  - Sentinel while IDLE: ignored.
- COLLECT:
  - Each tog: insert.
  - Sentinel: go DONE.
- DONE (1 clock):
  - done=1, busy=0, display_rank=0, dwell counter cleared, go DISPLAY.
- DISPLAY:
  - display_* driven combinationally from table[display_rank]; display_valid=(entry_count!=0).
  - Every DWELL_CYCLES clocks, display_rank increments and wraps to 0 after entry_count-1.
  - With entry_count==0, display_rank holds at 0.
- Restart: a tog (non-sentinel) in DISPLAY behaves as in IDLE (clear, insert, COLLECT).
  - display_valid drops the same clock the state leaves DISPLAY.
- entry_count saturates at TOP_N.
- Reset mid-list: table cleared, previous ranking lost, no done pulse.

Optional Feature:
- Macro SCOREBOARD_TIMEOUT_EN.
- Defined:
  - In COLLECT, an idle counter counts clocks with neither tog nor sentinel.
  - On reaching TIMEOUT_CYCLES: set timeout_err, go DONE, and display the partial list.
  - timeout_err clears on the next list start or on reset.
- Undefined: no counter; COLLECT waits indefinitely; timeout_err constant 0.

Test Plan:
- Scores in order: ids 0..5 with scores 10,50,30,50,0,70, then sentinel.
  - entry_count=4; ranks = (5,70),(1,50),(3,50),(2,30); done pulses once.
- Tie ordering: ids 7 and 2 both score 40, id 7 first.
  - Rank 0 = id 7, rank 1 = id 2.
- DWELL_CYCLES=4, 3 entries.
  - display_rank sequence 0,1,2,0 with changes every 4 clocks; display_valid held high.
- Sentinel with coincident parity toggle after 2 words.
  - No third insert; entry_count=2; done asserted.
- Assert rst mid-COLLECT after 3 words.
  - All outputs 0 immediately, no done pulse.
  - The next list builds from an empty table.
- SCOREBOARD_TIMEOUT_EN, TIMEOUT_CYCLES=16: 2 words, then silence.
  - At idle clock 16: timeout_err=1, done pulses, 2 entries displayed.
